// File: rtl/spi_mosi_tx.sv
// SPI MOSI transmitter: holding register feeding a shift register, zero-gap back-to-back frames.
// Define SPI_MOSI_LSB_FIRST_EN to shift LSB first; default build shifts MSB first.
module spi_mosi_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  spi_clk,
  input  logic                  n_reset,
  input  logic                  spi_cs,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  spi_mosi_out,
  output logic                  control_clk_mosi,
  output logic                  tx_done,
  output logic                  tx_abort
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_full_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  abort_r;
  logic                  load_s;
  logic                  abort_s;
  logic                  accept_s;
  logic                  last_s;

  // The bit on the wire is always the same end of shift_r; the register moves toward it.
  function automatic logic [DATA_WIDTH-1:0] shift_next(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_MOSI_LSB_FIRST_EN
    return {1'b0, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic wire_bit(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_MOSI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_WIDTH-1];
`endif
  endfunction

  assign accept_s = tx_valid & ~hold_full_r;
  assign last_s   = (bit_cnt_r == LAST_CNT);

  // State register.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic with the load and abort strobes it implies.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r && !spi_cs) begin
          state_nx_s = ST_SHIFT;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (spi_cs) begin
          state_nx_s = ST_IDLE;
          abort_s    = 1'b1;
        end else if (last_s) begin
          if (hold_full_r) begin
            state_nx_s = ST_SHIFT;
            load_s     = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; a chip-select abort during the last bit suppresses tx_done.
  always_comb begin
    tx_ready         = ~hold_full_r;
    tx_abort         = abort_r;
    spi_mosi_out     = 1'b0;
    control_clk_mosi = 1'b0;
    tx_done          = 1'b0;
    if (state_r == ST_SHIFT) begin
      spi_mosi_out     = wire_bit(shift_r);
      control_clk_mosi = 1'b1;
      tx_done          = last_s & ~spi_cs;
    end else begin
      spi_mosi_out     = 1'b0;
      control_clk_mosi = 1'b0;
      tx_done          = 1'b0;
    end
  end

  // Holding register: a fresh accept wins over the reload that empties it.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      hold_r      <= {DATA_WIDTH{1'b0}};
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_r      <= tx_data;
      hold_full_r <= 1'b1;
    end else if (load_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Shift register, bit counter and the registered abort pulse.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      abort_r   <= 1'b0;
    end else begin
      abort_r <= abort_s;
      if (load_s) begin
        shift_r   <= hold_r;
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (state_nx_s == ST_SHIFT) begin
        shift_r   <= shift_next(shift_r);
        bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
      end else begin
        shift_r   <= {DATA_WIDTH{1'b0}};
        bit_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_spi_mosi_tx.sv
// Directed self-checking bench for spi_mosi_tx (8-bit frames).
module tb_spi_mosi_tx;

  logic       spi_clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       spi_cs = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       spi_mosi_out;
  logic       control_clk_mosi;
  logic       tx_done;
  logic       tx_abort;

  int n_cmp = 0;
  int n_err = 0;

  spi_mosi_tx #(.DATA_WIDTH(8)) dut (
    .spi_clk          (spi_clk),
    .n_reset          (n_reset),
    .spi_cs           (spi_cs),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .spi_mosi_out     (spi_mosi_out),
    .control_clk_mosi (control_clk_mosi),
    .tx_done          (tx_done),
    .tx_abort         (tx_abort)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic step();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mosi"}, {31'd0, spi_mosi_out}, 32'd0);
    chk({tag, "_clk"}, {31'd0, control_clk_mosi}, 32'd0);
    chk({tag, "_done"}, {31'd0, tx_done}, 32'd0);
  endtask

  // Checks one frame starting in its first-bit cycle; optionally retargets tx_data/tx_valid after the first edge.
  task automatic check_frame(input string tag, input logic [7:0] w, input logic upd,
                             input logic [7:0] nd, input logic nv);
    logic exp_bit;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_MOSI_LSB_FIRST_EN
      exp_bit = w[i];
`else
      exp_bit = w[7-i];
`endif
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, spi_mosi_out}, {31'd0, exp_bit});
      chk($sformatf("%s_clk%0d", tag, i), {31'd0, control_clk_mosi}, 32'd1);
      chk($sformatf("%s_done%0d", tag, i), {31'd0, tx_done}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("%s_abort%0d", tag, i), {31'd0, tx_abort}, 32'd0);
      step();
      if (i == 0 && upd) begin
        tx_data  = nd;
        tx_valid = nv;
      end
    end
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_abort", {31'd0, tx_abort}, 32'd0);
    chk_idle("rst");
    #16;
    n_reset = 1'b1;
    step();

    // Single frame A5, first bit two cycles after accept
    spi_cs   = 1'b0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("single_ready_after_accept", {31'd0, tx_ready}, 32'd0);
    chk_idle("single_cyc1");
    step();
    check_frame("single", 8'hA5, 1'b0, 8'h00, 1'b0);
    chk("single_ready_end", {31'd0, tx_ready}, 32'd1);
    chk_idle("single_end");

    // Back-to-back 80 then 01; 01 offered early while holding register is full
    tx_data  = 8'h80;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h01;
    chk("b2b_ready_full", {31'd0, tx_ready}, 32'd0);
    step();
    chk("b2b_ready_loaded", {31'd0, tx_ready}, 32'd1);
    check_frame("b2b_a", 8'h80, 1'b1, 8'h00, 1'b0);
    chk("b2b_ready_reload", {31'd0, tx_ready}, 32'd1);
    check_frame("b2b_b", 8'h01, 1'b0, 8'h00, 1'b0);
    chk_idle("b2b_end");

    // Backpressure: three words with tx_valid held high
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h5A;
    chk("bp_ready_0", {31'd0, tx_ready}, 32'd0);
    step();
    chk("bp_ready_1", {31'd0, tx_ready}, 32'd1);
    check_frame("bp_a", 8'hC3, 1'b1, 8'hE7, 1'b1);
    chk("bp_ready_after_reload", {31'd0, tx_ready}, 32'd1);
    check_frame("bp_b", 8'h5A, 1'b1, 8'h00, 1'b0);
    check_frame("bp_c", 8'hE7, 1'b0, 8'h00, 1'b0);
    chk_idle("bp_end");
    chk("bp_ready_end", {31'd0, tx_ready}, 32'd1);

    // Abort after three bits of FF with 3C held
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h3C;
    step();
    chk("ab_bit0", {31'd0, spi_mosi_out}, 32'd1);
    step();
    tx_valid = 1'b0;
    chk("ab_bit1", {31'd0, spi_mosi_out}, 32'd1);
    step();
    chk("ab_bit2", {31'd0, spi_mosi_out}, 32'd1);
    spi_cs = 1'b1;
    #1;
    chk("ab_no_done_cs", {31'd0, tx_done}, 32'd0);
    step();
    chk("ab_pulse", {31'd0, tx_abort}, 32'd1);
    chk("ab_ready_held", {31'd0, tx_ready}, 32'd0);
    chk_idle("ab_idle");
    step();
    chk("ab_pulse_end", {31'd0, tx_abort}, 32'd0);
    chk_idle("ab_cs_high");
    spi_cs = 1'b0;
    step();
    check_frame("ab_resume", 8'h3C, 1'b0, 8'h00, 1'b0);
    chk_idle("ab_end");

    // Reset mid-frame takes effect without a clock edge
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    step();
    chk("mid_clk_active", {31'd0, control_clk_mosi}, 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rst_abort", {31'd0, tx_abort}, 32'd0);
    chk_idle("mid_rst");
    #2;
    n_reset  = 1'b1;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("post_rst_accept", {31'd0, tx_ready}, 32'd0);
    chk("post_rst_no_abort", {31'd0, tx_abort}, 32'd0);
    step();
    check_frame("post_rst", 8'h96, 1'b0, 8'h00, 1'b0);
    chk_idle("post_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
